// File: rtl/edge_event_scheduler.sv
// Falling-edge event scheduler.
// Captures masked falling edges into sticky per-bit pending flags and hands them one at a
// time to a consumer over valid/ready. Pending bits are served in round-robin order,
// starting after the last accepted index. An edge that arrives on a bit that is still
// pending is recorded in a sticky overflow flag. Software clears overflow flags with
// write-1-to-clear pulses.
module edge_event_scheduler #(
    parameter  int unsigned WIDTH = 32,
    localparam int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] mask_i,
    output logic             evt_valid_o,
    output logic [IDX_W-1:0] evt_idx_o,
    input  logic             evt_ready_i,
    output logic [WIDTH-1:0] pending_o,
    output logic [WIDTH-1:0] ovf_o,
    input  logic [WIDTH-1:0] ovf_clr_i
);

    typedef enum logic {
        StIdle,
        StOffer
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_data_q;
    logic [WIDTH-1:0]   r_pending;
    logic [WIDTH-1:0]   r_ovf;
    logic [IDX_W-1:0]   r_ptr;
    logic               r_evt_valid;
    logic [IDX_W-1:0]   r_evt_idx;

    logic [WIDTH-1:0]   w_fall;
    logic               w_accept;
    logic [WIDTH-1:0]   w_clr;
    logic [2*WIDTH-1:0] w_dbl;
    logic [WIDTH-1:0]   w_rot;
    logic [IDX_W-1:0]   w_off;
    logic [IDX_W:0]     w_sum;
    logic               w_sel_found;
    logic [IDX_W-1:0]   w_sel_idx;

    // Edge detect, accept and per-bit clear decode.
    always_comb begin
        w_fall   = r_data_q & ~data_i & mask_i;
        w_accept = r_evt_valid & evt_ready_i;
        w_clr    = '0;
        if (w_accept) begin
            w_clr = WIDTH'(1) << r_evt_idx;
        end
    end

    // Round-robin pick: rotate pending so ptr lands at bit 0, take the lowest set bit,
    // then rotate the offset back into an absolute index.
    always_comb begin
        w_dbl = {r_pending, r_pending};
        w_rot = WIDTH'(w_dbl >> r_ptr);
        w_off = '0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDX_W'(k);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= (IDX_W + 1)'(WIDTH)) begin
            w_sum = w_sum - (IDX_W + 1)'(WIDTH);
        end
        w_sel_idx   = w_sum[IDX_W-1:0];
        w_sel_found = |r_pending;
    end

    // Input history, sticky pending and overflow flags; a set beats any clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_q  <= '0;
            r_pending <= '0;
            r_ovf     <= '0;
        end else begin
            r_data_q  <= data_i;
            r_pending <= w_fall | (r_pending & ~w_clr);
            r_ovf     <= (w_fall & r_pending & ~w_clr) | (r_ovf & ~ovf_clr_i);
        end
    end

    // Offer FSM with registered valid/index; the pointer only moves on accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_ptr       <= '0;
            r_evt_valid <= 1'b0;
            r_evt_idx   <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_sel_found) begin
                        r_state     <= StOffer;
                        r_evt_valid <= 1'b1;
                        r_evt_idx   <= w_sel_idx;
                    end
                end
                StOffer: begin
                    if (evt_ready_i) begin
                        r_state     <= StIdle;
                        r_evt_valid <= 1'b0;
                        r_ptr       <= (r_evt_idx == IDX_W'(WIDTH - 1)) ?
                                       '0 : r_evt_idx + 1'b1;
                    end
                end
                default: begin
                    r_state     <= StIdle;
                    r_evt_valid <= 1'b0;
                end
            endcase
        end
    end

    assign evt_valid_o = r_evt_valid;
    assign evt_idx_o   = r_evt_idx;
    assign pending_o   = r_pending;
    assign ovf_o       = r_ovf;

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Bench for edge_event_scheduler: directed scenarios with literal expectations, plus a
// cycle-level reference model compared on every falling clock edge.
module tb_edge_event_scheduler;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned IDX_W = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] data_i;
    logic [WIDTH-1:0] mask_i;
    logic             evt_valid_o;
    logic [IDX_W-1:0] evt_idx_o;
    logic             evt_ready_i;
    logic [WIDTH-1:0] pending_o;
    logic [WIDTH-1:0] ovf_o;
    logic [WIDTH-1:0] ovf_clr_i;

    int n_cmp = 0;
    int n_bad = 0;

    edge_event_scheduler #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .data_i     (data_i),
        .mask_i     (mask_i),
        .evt_valid_o(evt_valid_o),
        .evt_idx_o  (evt_idx_o),
        .evt_ready_i(evt_ready_i),
        .pending_o  (pending_o),
        .ovf_o      (ovf_o),
        .ovf_clr_i  (ovf_clr_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of flags served in rotating order.
    bit               m_valid;
    int               m_idx;
    int               m_ptr;
    bit [WIDTH-1:0]   m_pend;
    bit [WIDTH-1:0]   m_ovf;
    bit [WIDTH-1:0]   m_prev;

    always @(posedge clk or posedge reset) begin
        bit [WIDTH-1:0] nx_pend;
        bit [WIDTH-1:0] nx_ovf;
        bit             acc;
        bit             fall;
        bit             gone;
        bit             nx_valid;
        int             nx_idx;
        int             nx_ptr;
        if (reset) begin
            m_valid <= 1'b0;
            m_idx   <= 0;
            m_ptr   <= 0;
            m_pend  <= '0;
            m_ovf   <= '0;
            m_prev  <= '0;
        end else begin
            acc = m_valid && evt_ready_i;
            for (int i = 0; i < WIDTH; i++) begin
                fall = m_prev[i] && !data_i[i] && mask_i[i];
                gone = acc && (m_idx == i);
                nx_pend[i] = fall || (m_pend[i] && !gone);
                nx_ovf[i]  = (fall && m_pend[i] && !gone) || (m_ovf[i] && !ovf_clr_i[i]);
            end
            nx_valid = m_valid;
            nx_idx   = m_idx;
            nx_ptr   = m_ptr;
            if (m_valid) begin
                if (acc) begin
                    nx_valid = 1'b0;
                    nx_ptr   = (m_idx + 1) % WIDTH;
                end
            end else begin
                for (int k = 0; k < WIDTH; k++) begin
                    if (!nx_valid && m_pend[(m_ptr + k) % WIDTH]) begin
                        nx_valid = 1'b1;
                        nx_idx   = (m_ptr + k) % WIDTH;
                    end
                end
            end
            m_valid <= nx_valid;
            m_idx   <= nx_idx;
            m_ptr   <= nx_ptr;
            m_pend  <= nx_pend;
            m_ovf   <= nx_ovf;
            m_prev  <= data_i;
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model_valid", {63'b0, evt_valid_o}, {63'b0, m_valid});
        if (m_valid) check("model_idx", 64'(evt_idx_o), 64'(m_idx));
        check("model_pending", 64'(pending_o), 64'(m_pend));
        check("model_ovf", 64'(ovf_o), 64'(m_ovf));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [WIDTH-1:0] bits);
        data_i = data_i & ~bits;
        tick();
        data_i = data_i | bits;
        tick();
    endtask

    task automatic expect_offer(input int exp, input string name);
        int n;
        n = 0;
        while (!evt_valid_o && n < 10) begin
            tick();
            n++;
        end
        check({name, "_valid"}, {63'b0, evt_valid_o}, 64'd1);
        check({name, "_idx"}, 64'(evt_idx_o), 64'(exp));
    endtask

    initial begin
        reset       = 1'b1;
        data_i      = '1;
        mask_i      = '1;
        evt_ready_i = 1'b1;
        ovf_clr_i   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {63'b0, evt_valid_o}, 64'd0);
        check("rst_idx", 64'(evt_idx_o), 64'd0);
        check("rst_pending", 64'(pending_o), 64'd0);
        check("rst_ovf", 64'(ovf_o), 64'd0);
        reset = 1'b0;
        tick();
        tick();
        check("idle_no_event", {63'b0, evt_valid_o}, 64'd0);

        // Round robin from ptr=0, then wrap from ptr=11.
        pulse(32'h0000_0408);
        expect_offer(3, "rr_first");
        tick();
        expect_offer(10, "rr_second");
        tick();
        pulse(32'h8000_0001);
        expect_offer(31, "wrap_first");
        tick();
        expect_offer(0, "wrap_second");
        tick();

        // Single edge on bit 5 with exact latency.
        data_i[5] = 1'b0;
        tick();
        check("single_pend", 64'(pending_o), 64'h20);
        check("single_not_yet", {63'b0, evt_valid_o}, 64'd0);
        data_i[5] = 1'b1;
        tick();
        check("single_valid", {63'b0, evt_valid_o}, 64'd1);
        check("single_idx", 64'(evt_idx_o), 64'd5);
        tick();
        check("single_cleared", 64'(pending_o), 64'd0);
        check("single_done", {63'b0, evt_valid_o}, 64'd0);

        // Backpressure: idx 7 held while 2 and 9 arrive.
        evt_ready_i = 1'b0;
        pulse(32'h0000_0080);
        expect_offer(7, "bp_offer");
        data_i = data_i & ~32'h0000_0204;
        tick();
        data_i = '1;
        for (int c = 0; c < 6; c++) begin
            check("bp_hold_valid", {63'b0, evt_valid_o}, 64'd1);
            check("bp_hold_idx", 64'(evt_idx_o), 64'd7);
            if (c < 5) tick();
        end
        check("bp_pending", 64'(pending_o), 64'h0000_0284);
        evt_ready_i = 1'b1;
        tick();
        expect_offer(9, "bp_next");
        tick();
        expect_offer(2, "bp_last");
        tick();

        // Overflow, W1C, and edge in the accept cycle.
        evt_ready_i = 1'b0;
        pulse(32'h0000_0010);
        expect_offer(4, "ovf_offer");
        pulse(32'h0000_0010);
        check("ovf_set", 64'(ovf_o), 64'h10);
        ovf_clr_i[4] = 1'b1;
        tick();
        ovf_clr_i[4] = 1'b0;
        check("ovf_cleared", 64'(ovf_o), 64'd0);
        data_i[4]   = 1'b0;
        evt_ready_i = 1'b1;
        tick();
        data_i[4] = 1'b1;
        check("rearm_pend", 64'(pending_o), 64'h10);
        check("rearm_no_ovf", 64'(ovf_o), 64'd0);
        check("rearm_idle", {63'b0, evt_valid_o}, 64'd0);
        expect_offer(4, "rearm_offer");
        tick();

        // Mask gating.
        mask_i[12] = 1'b0;
        pulse(32'h0000_1000);
        tick();
        check("mask_no_pend", 64'(pending_o), 64'd0);
        check("mask_no_evt", {63'b0, evt_valid_o}, 64'd0);
        mask_i[12]  = 1'b1;
        evt_ready_i = 1'b0;
        data_i[12]  = 1'b0;
        tick();
        mask_i[12] = 1'b0;
        data_i[12] = 1'b1;
        expect_offer(12, "mask_dropped");
        evt_ready_i = 1'b1;
        tick();
        mask_i = '1;

        // Asynchronous reset while offering with pending=0xF00.
        evt_ready_i = 1'b0;
        pulse(32'h0000_0F00);
        check("pre_rst_pend", 64'(pending_o), 64'h0F00);
        check("pre_rst_idx", 64'(evt_idx_o), 64'd8);
        #2;
        reset  = 1'b1;
        data_i = '0;
        #1;
        check("async_valid", {63'b0, evt_valid_o}, 64'd0);
        check("async_pend", 64'(pending_o), 64'd0);
        check("async_ovf", 64'(ovf_o), 64'd0);
        tick();
        tick();
        reset       = 1'b0;
        evt_ready_i = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("post_rst_quiet", {63'b0, evt_valid_o}, 64'd0);
            check("post_rst_pend", 64'(pending_o), 64'd0);
        end
        data_i = '1;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/edge_event_scheduler.md
Name: edge_event_scheduler

Overview:
- Captures falling edges on a WIDTH-bit input bus into per-bit sticky pending flags.
- Schedules pending flags one at a time to a downstream consumer over a valid/ready handshake, using round-robin priority.
- Clears each flag when its event is accepted and flags any edges lost while a bit is already pending.
- Sits between raw status lines and the interrupt/event-service logic; replaces free-running sticky capture with a serviced, per-bit-clearing queue.

Parameters:
- WIDTH, 32, number of monitored input bits (2..64).
- IDX_W, $clog2(WIDTH), event index width. Derived; not overridden.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- data_i  input  WIDTH  monitored lines, synchronous to clk.
- mask_i  input  WIDTH  per-bit capture enable; 1 = edges on that bit are captured.
- evt_valid_o  output  1  event offered.
- evt_idx_o  output  IDX_W  index of the offered bit.
- evt_ready_i  input  1  consumer accepts the event when evt_valid_o && evt_ready_i.
- pending_o  output  WIDTH  current sticky pending flags.
- ovf_o  output  WIDTH  sticky overflow flags: an edge was lost on a bit already pending.
- ovf_clr_i  input  WIDTH  write-1-to-clear for ovf_o, one-cycle pulse per bit.

Behaviour:
- Reset (async): data_q=0, pending=0, ovf=0, ptr=0, state=IDLE, evt_valid_o=0, evt_idx_o=0.
- Edge detect: fall[i] = data_q[i] & ~data_i[i] & mask_i[i]. data_q <= data_i every cycle. Rising edges are ignored.
- The first cycle after reset cannot produce an edge, because data_q=0.
- Pending update each clock, per bit: pending[i] <= fall[i] | (pending[i] & ~clr[i]). clr[i] = accept && evt_idx_o==i. A set wins over a clear in the same cycle.
- mask_i only gates capture. Deasserting a mask bit does not clear an existing pending flag; that flag is still scheduled.
- Overflow: ovf[i] <= (fall[i] & pending[i] & ~clr[i]) | (ovf[i] & ~ovf_clr_i[i]). A set wins over ovf_clr_i.
- An edge arriving in the same cycle as that bit's accept re-arms the pending flag without setting overflow.
- FSM, 2 states:
  - IDLE: evt_valid_o=0. If pending != 0, select the first set bit searching ptr, ptr+1, ..., WIDTH-1, 0, ..., ptr-1. Register it into evt_idx_o and go to OFFER. Otherwise stay in IDLE.
  - OFFER: evt_valid_o=1. evt_idx_o is held stable until acceptance. On accept: clear pending[idx], ptr <= (idx==WIDTH-1) ? 0 : idx+1, go to IDLE. Without accept: stay in OFFER with all outputs unchanged.
- Selection uses the pending register value, not the bits being set in the current cycle.
- Latency: data_i low sampled at edge N (data_q=1) → pending set after edge N → evt_valid_o=1 after edge N+1. Minimum spacing between accepts is 2 cycles.
- evt_valid_o and evt_idx_o are registered. There is no combinational path from evt_ready_i to any output except through clocked state.
- ptr changes only on accept. An empty scan in IDLE leaves ptr unchanged.
- Reset mid-OFFER drops the offered event and all pending state. Post-reset behaviour is as at power-up.
- Size: RTL 150–250 lines (edge regs, pending/ovf vectors, rotate-priority select, 2-state FSM).

Test Plan:
- Single edge: WIDTH=32, mask all 1, data_i[5] 1→0 at cycle 10. Required: pending_o[5]=1 from cycle 11, evt_valid_o=1 with evt_idx_o=5 from cycle 12. With evt_ready_i=1: accept at 12, pending_o[5]=0 at 13, ptr=6.
- Round-robin and wrap: from ptr=0, edges on bits 3 and 10 in the same cycle → idx 3, then idx 10. Next, edges on bits 0 and 31 with ptr=11 → idx 31, then idx 0, and ptr ends at 1.
- Backpressure: event idx 7 offered with evt_ready_i=0 for 6 cycles while edges arrive on bits 2 and 9. Required: evt_idx_o stays 7 and evt_valid_o stays 1 throughout. After accept, the next offer is idx 9 (ptr=8), then idx 2.
- Overflow / set-vs-clear: a second edge on bit 4 while pending → ovf_o[4]=1, and ovf_clr_i[4] pulse clears it. An edge on bit 4 in the accept cycle of idx 4 → pending_o[4] stays 1 and ovf_o[4] stays 0.
- Mask: mask_i[12]=0 with an edge on bit 12 → no pending, no event. Edge captured with mask_i[12]=1, then mask dropped → event 12 still offered.
- Reset mid-operation: assert reset asynchronously while in OFFER with pending=0x0000_0F00. Required: evt_valid_o, pending_o and ovf_o are 0 immediately. After release, data_i held low produces no event.
